// File: rtl/conv1_layer1_acc_tree.sv
// Pipelined 25-input adder tree plus group accumulator for the conv1 layer1 product beats.
// Produces a full-precision group sum and a saturated 16-bit fixed-point copy.
module conv1_layer1_acc_tree #(
  parameter int NUM_BEATS  = 4,
  parameter int ACC_W      = 48,
  parameter int FRAC_SHIFT = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mult_res_v,
  input  logic [799:0]     mult_res,
  output logic [ACC_W-1:0] acc_res,
  output logic [15:0]      acc_res_q,
  output logic             acc_res_v,
  output logic             sat_flag,
  output logic             busy,
  output logic [1:0]       fsm_state_o
);

  // Handshake: mult_res_v is a one-cycle valid with no ready; acc_res_v is a
  // one-cycle pulse during which acc_res/acc_res_q/sat_flag carry a new result.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  typedef logic signed [ACC_W-1:0] sum_t;

  localparam logic [4:0] LAST_BEAT = 5'(NUM_BEATS - 1);
  localparam sum_t       Q_MAX     = sum_t'(32767);
  localparam sum_t       Q_MIN     = sum_t'(-32768);

  sum_t s0 [25];
  sum_t st1_d [13];
  sum_t st1_q [13];
  sum_t st2_d [7];
  sum_t st2_q [7];
  sum_t st3_d [4];
  sum_t st3_q [4];
  sum_t st4_d [2];
  sum_t st4_q [2];
  sum_t st5_d;
  sum_t st5_q;
  logic [4:0] vld_q;

  always_comb begin
    for (int k = 0; k < 25; k++) s0[k] = ACC_W'($signed(mult_res[32*k +: 32]));
    for (int i = 0; i < 12; i++) st1_d[i] = s0[2*i] + s0[2*i+1];
    st1_d[12] = s0[24];
    for (int i = 0; i < 6; i++) st2_d[i] = st1_q[2*i] + st1_q[2*i+1];
    st2_d[6] = st1_q[12];
    for (int i = 0; i < 3; i++) st3_d[i] = st2_q[2*i] + st2_q[2*i+1];
    st3_d[3] = st2_q[6];
    st4_d[0] = st3_q[0] + st3_q[1];
    st4_d[1] = st3_q[2] + st3_q[3];
    st5_d    = st4_q[0] + st4_q[1];
  end

  // Each stage only captures when its incoming valid is set, so data holds across idle cycles.
  always_ff @(posedge clk) begin
    if (mult_res_v) st1_q <= st1_d;
    if (vld_q[0])   st2_q <= st2_d;
    if (vld_q[1])   st3_q <= st3_d;
    if (vld_q[2])   st4_q <= st4_d;
    if (vld_q[3])   st5_q <= st5_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       vld_q <= '0;
    else if (start) vld_q <= {4'b0000, mult_res_v};
    else            vld_q <= {vld_q[3:0], mult_res_v};
  end

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  sum_t              acc_q, acc_d;
  sum_t              grp_sum;
  sum_t              shifted;
  logic              tree_v;
  logic              last_beat;
  logic [15:0]       fix_d;
  logic              sat_d;
  logic [ACC_W-1:0]  out_sum_q;
  logic [15:0]       out_fix_q;
  logic              out_sat_q;

  assign tree_v    = vld_q[4];
  assign last_beat = tree_v && (cnt_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    grp_sum = (cnt_q == '0) ? st5_q : acc_q + st5_q;
    case (state_q)
      S_IDLE:   if (tree_v) state_d = last_beat ? S_OUTPUT : S_ACCUM;
      S_ACCUM:  if (last_beat) state_d = S_OUTPUT;
      S_OUTPUT: state_d = tree_v ? (last_beat ? S_OUTPUT : S_ACCUM) : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (tree_v) begin
      acc_d = grp_sum;
      cnt_d = last_beat ? 5'd0 : 5'(cnt_q + 5'd1);
    end
    if (start) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end
  end

  always_comb begin
    shifted = grp_sum >>> FRAC_SHIFT;
    fix_d   = shifted[15:0];
    sat_d   = 1'b0;
    if (shifted > Q_MAX) begin
      fix_d = 16'h7FFF;
      sat_d = 1'b1;
    end else if (shifted < Q_MIN) begin
      fix_d = 16'h8000;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      out_sum_q <= '0;
      out_fix_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (last_beat && !start) begin
        out_sum_q <= grp_sum;
        out_fix_q <= fix_d;
        out_sat_q <= sat_d;
      end
    end
  end

  // The result pulse is exactly the single cycle spent in OUTPUT.
  assign acc_res_v   = (state_q == S_OUTPUT);
  assign acc_res     = out_sum_q;
  assign acc_res_q   = out_fix_q;
  assign sat_flag    = out_sat_q;
  assign busy        = (|vld_q) || (cnt_q != '0);
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_conv1_layer1_acc_tree.sv
// Randomized self-checking bench for conv1_layer1_acc_tree against a group-sum reference model.
module tb_conv1_layer1_acc_tree;

  localparam int NB = 4;
  localparam int AW = 48;
  localparam int FS = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          mult_res_v = 1'b0;
  logic [799:0]  mult_res = '0;
  logic [AW-1:0] acc_res;
  logic [15:0]   acc_res_q;
  logic          acc_res_v;
  logic          sat_flag;
  logic          busy;
  logic [1:0]    fsm_state;

  conv1_layer1_acc_tree #(.NUM_BEATS(NB), .ACC_W(AW), .FRAC_SHIFT(FS)) dut (
    .clk(clk), .rst(rst), .start(start), .mult_res_v(mult_res_v), .mult_res(mult_res),
    .acc_res(acc_res), .acc_res_q(acc_res_q), .acc_res_v(acc_res_v), .sat_flag(sat_flag),
    .busy(busy), .fsm_state_o(fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [63:0] exp_q[$];
  int          due_q[$];
  int          pulse_q[$];
  longint      grp_acc = 0;
  int          grp_cnt = 0;
  logic [63:0] last_acc = '0;
  logic [15:0] last_fix = '0;
  logic signed [31:0] prod [25];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] quant(input longint a);
    longint s;
    s = a >>> FS;
    if (s > 32767) return {1'b1, 16'h7FFF};
    else if (s < -32768) return {1'b1, 16'h8000};
    else return {1'b0, s[15:0]};
  endfunction

  function automatic logic [63:0] sext(input logic [AW-1:0] v);
    return 64'(longint'($signed(v)));
  endfunction

  // driver: one call per clock; inputs change 1 time unit after the edge
  task automatic drive(input logic v, input logic st, input logic [799:0] d, input longint bsum);
    @(posedge clk);
    #1;
    mult_res_v = v;
    start      = st;
    mult_res   = d;
    if (st) begin
      while (due_q.size() > 0 && due_q[due_q.size()-1] > cyc) begin
        void'(exp_q.pop_back());
        void'(due_q.pop_back());
      end
      grp_cnt = 0;
      grp_acc = 0;
    end
    if (v) begin
      grp_acc += bsum;
      grp_cnt++;
      if (grp_cnt == NB) begin
        exp_q.push_back(grp_acc);
        due_q.push_back(cyc + 6);
        grp_cnt = 0;
        grp_acc = 0;
      end
    end
  endtask

  task automatic send(input logic st);
    logic [799:0] d;
    longint s;
    s = 0;
    for (int k = 0; k < 25; k++) begin
      d[32*k +: 32] = prod[k];
      s += longint'(prod[k]);
    end
    drive(1'b1, st, d, s);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, 0);
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int k = 0; k < 25; k++) prod[k] = v;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 25; k++) prod[k] = $urandom();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle(1);
    idle(2);
    check_val({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // scoreboard / monitor, sampled on the falling edge
  logic [63:0] mon_e;
  logic [16:0] mon_q;
  int          mon_d;
  always @(negedge clk) begin
    if (rst) begin
      if (acc_res_v) begin
        pulse_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_val("unexpected_v", 64'(acc_res_v), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_d = due_q.pop_front();
          mon_q = quant(longint'(mon_e));
          check_val("acc_res", sext(acc_res), mon_e);
          check_val("acc_res_q", 64'(acc_res_q), 64'(mon_q[15:0]));
          check_val("sat_flag", 64'(sat_flag), 64'(mon_q[16]));
          check_val("latency", 64'(cyc), 64'(mon_d));
          last_acc = mon_e;
          last_fix = mon_q[15:0];
        end
      end else begin
        check_val("hold", {acc_res_q, acc_res}, {last_fix, last_acc[AW-1:0]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int n0;

  initial begin
    // reset
    #12;
    check_val("rst_acc", 64'(acc_res), 64'd0);
    check_val("rst_q", 64'(acc_res_q), 64'd0);
    check_val("rst_v", 64'(acc_res_v), 64'd0);
    check_val("rst_sat", 64'(sat_flag), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // single group of ones
    fill_const(32'd1);
    repeat (4) send(1'b0);
    drain("ones");
    check_val("ones_acc", sext(acc_res), 64'd100);
    check_val("ones_q", 64'(acc_res_q), 64'd0);
    check_val("ones_sat", 64'(sat_flag), 64'd0);

    // signed mix
    for (int k = 0; k < 25; k++) prod[k] = k - 12;
    send(1'b0);
    fill_const(-32'sd4096);
    send(1'b0);
    fill_const(32'd0);
    send(1'b0);
    send(1'b0);
    drain("mix");
    check_val("mix_acc", sext(acc_res), -64'sd102400);
    check_val("mix_q", 64'(acc_res_q), 64'(16'hFFE7));

    // positive and negative saturation
    fill_const(32'h7FFFFFFF);
    repeat (4) send(1'b0);
    drain("satp");
    check_val("satp_acc", sext(acc_res), 64'sd214748364700);
    check_val("satp_q", 64'(acc_res_q), 64'(16'h7FFF));
    check_val("satp_flag", 64'(sat_flag), 64'd1);
    fill_const(32'h80000000);
    repeat (4) send(1'b0);
    drain("satn");
    check_val("satn_acc", sext(acc_res), -64'sd214748364800);
    check_val("satn_q", 64'(acc_res_q), 64'(16'h8000));
    check_val("satn_flag", 64'(sat_flag), 64'd1);

    // random beats with gaps
    n0 = pulse_q.size();
    for (int b = 0; b < 8; b++) begin
      fill_rand();
      send(1'b0);
      idle($urandom_range(1, 3));
    end
    drain("gaps");
    check_val("gaps_pulses", 64'(pulse_q.size() - n0), 64'd2);

    // continuous beats, back-to-back groups
    n0 = pulse_q.size();
    for (int b = 0; b < 8; b++) begin
      fill_rand();
      send(1'b0);
    end
    drain("b2b");
    check_val("b2b_pulses", 64'(pulse_q.size() - n0), 64'd2);
    check_val("b2b_spacing", 64'(pulse_q[pulse_q.size()-1] - pulse_q[pulse_q.size()-2]), 64'd4);

    // mixed random gaps including zero
    for (int b = 0; b < 12; b++) begin
      fill_rand();
      send(1'b0);
      idle($urandom_range(0, 2));
    end
    drain("rnd");

    // abort with start coincident with a new beat
    n0 = pulse_q.size();
    fill_rand();
    send(1'b0);
    send(1'b0);
    check_val("abort_busy", 64'(busy), 64'd1);
    fill_const(32'd2);
    send(1'b1);
    repeat (3) send(1'b0);
    drain("abort");
    check_val("abort_pulses", 64'(pulse_q.size() - n0), 64'd1);
    check_val("abort_acc", sext(acc_res), 64'd200);

    // asynchronous reset mid-group
    fill_rand();
    send(1'b0);
    send(1'b0);
    idle(1);
    #3;
    rst = 1'b0;
    exp_q.delete();
    due_q.delete();
    grp_cnt  = 0;
    grp_acc  = 0;
    last_acc = '0;
    last_fix = '0;
    #1;
    check_val("arst_acc", 64'(acc_res), 64'd0);
    check_val("arst_q", 64'(acc_res_q), 64'd0);
    check_val("arst_v", 64'(acc_res_v), 64'd0);
    check_val("arst_sat", 64'(sat_flag), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    n0 = pulse_q.size();
    for (int b = 0; b < 4; b++) begin
      fill_rand();
      send(1'b0);
    end
    drain("post_rst");
    check_val("post_rst_pulses", 64'(pulse_q.size() - n0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv1_layer1_acc_tree.md
Name: conv1_layer1_acc_tree

Overview:
Downstream consumer of the conv1 layer1 dense multiplier array.
- Takes each 800-bit product beat (25 signed 32-bit products) and reduces it to one sum through a pipelined adder tree.
- Accumulates NUM_BEATS consecutive beats into one dot-product result.
- Emits the full-precision result and a saturated 16-bit fixed-point result to the conv1 activation/writeback stage.

Parameters:
- NUM_BEATS, 4, product beats accumulated per output (legal range 1..16).
- ACC_W, 48, width of the full-precision accumulator and acc_res.
- FRAC_SHIFT, 12, arithmetic right shift applied before 16-bit quantisation (legal range 0..31).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new accumulation group.
- mult_res_v  input  1  one-cycle valid for mult_res; may be asserted on consecutive cycles.
- mult_res  input  800  25 signed 32-bit products; product k at bits [32k+31:32k].
- acc_res  output  ACC_W  full-precision signed group sum.
- acc_res_q  output  16  saturated signed (acc_res >>> FRAC_SHIFT).
- acc_res_v  output  1  one-cycle pulse when acc_res/acc_res_q are updated.
- sat_flag  output  1  set with acc_res_v when acc_res_q saturated.
- busy  output  1  high while any beat is in the tree or the group is incomplete.

Behaviour:
- Reset (rst low, asynchronous): all pipeline valid bits, beat counter, accumulator, acc_res, acc_res_q, acc_res_v, sat_flag and busy are cleared to 0. The FSM goes to IDLE.
- Arithmetic:
  - All products are signed two's complement, sign-extended to ACC_W before the first add.
  - No truncation inside the tree or the accumulator.
  - ACC_W=48 cannot overflow for 16 beats of 25 products.
- Adder tree is 5 registered stages: 25→13→7→4→2→1.
  - At each stage, odd leftover operands pass through registered unchanged.
  - A valid bit travels with each stage.
- Accumulator stage (6th register):
  - Tree-out valid with beat counter 0: acc <= tree_sum.
  - Tree-out valid otherwise: acc <= acc + tree_sum.
  - Beat counter increments on each tree-out valid.
- Latency: mult_res_v of the final beat at cycle t → acc_res_v high at cycle t+6.
- Throughput: one beat per cycle, no backpressure. The upstream guarantees at most one mult_res_v per cycle.
- FSM:
  - IDLE: counter=0. On tree-out valid → ACCUM, or → OUTPUT if NUM_BEATS=1.
  - ACCUM: on tree-out valid with counter==NUM_BEATS-1 → OUTPUT, else stay.
  - OUTPUT: a single cycle in which the acc_res_v pulse is driven; counter cleared; → IDLE. A tree-out valid arriving in this same cycle starts the next group as beat 0 (back-to-back groups, no bubble).
- Output register:
  - acc_res and acc_res_q hold their value until the next group completes.
  - Quantisation: s = acc >>> FRAC_SHIFT.
    - If s > 32767: acc_res_q = 16'h7FFF, sat_flag = 1.
    - If s < -32768: acc_res_q = 16'h8000, sat_flag = 1.
    - Otherwise: acc_res_q = s[15:0], sat_flag = 0.
  - sat_flag is updated only together with acc_res_v.
- start:
  - Synchronously clears all tree valid bits, the counter and the accumulator; FSM → IDLE. In-flight beats are dropped.
  - A mult_res_v coincident with start is accepted as beat 0 of the new group.
  - acc_res and acc_res_q are not cleared by start.
- busy = (any tree valid bit) OR (counter != 0).
- mult_res_v low: tree stages hold their data, and no accumulation occurs.

Test Plan:
- Single group: NUM_BEATS=4, four consecutive beats with all 25 products = 1 → acc_res=100, acc_res_q=0 (FRAC_SHIFT=12), acc_res_v exactly 6 cycles after the 4th mult_res_v, sat_flag=0.
- Signed mix: one beat, products k=0..24 equal to (k-12) → sum 0; a second beat with all products = -4096, then two beats of zeros → acc_res=-102400, acc_res_q=-25.
- Saturation: four beats, all products 32'h7FFFFFFF → acc_res=214748364700, acc_res_q=16'h7FFF, sat_flag=1. The same test with 32'h80000000 → acc_res_q=16'h8000, sat_flag=1.
- Back-to-back and gaps: 8 beats with 1–3 idle cycles between random beats → two acc_res_v pulses, each matching the reference model sum. Continuous 8 beats → pulses exactly 4 cycles apart.
- Abort: after 2 beats, start is pulsed together with a new beat, followed by 3 more beats of value 2 → one acc_res_v with acc_res=200. Earlier beats are discarded.
- Async reset mid-group: rst low between the 2nd and 3rd beats, asserted off-edge → all outputs 0 immediately. The next 4 beats produce a correct fresh result.
